// File: rtl/pipe_stall_ctrl_if.sv
// rtl/pipe_stall_ctrl_if.sv - MEM-stage data-SRAM-like handshake between stall controller and memory
interface pipe_stall_ctrl_if;
    logic        data_req;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    modport master (
        output data_req,
        input  data_addr_ok,
        input  data_data_ok,
        input  data_rdata
    );

    modport slave (
        input  data_req,
        output data_addr_ok,
        output data_data_ok,
        output data_rdata
    );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// rtl/pipe_stall_ctrl.sv - pipeline hazard/stall scheduler with MEM handshake; PERF_CNT_EN adds stall-cycle counters
module pipe_stall_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic        clk,
    input  logic        rst,
    pipe_stall_ctrl_if.master mem,
    input  logic        mem_enM,
    output logic [31:0] mem_rdataM,
    input  logic        lwstallD,
    input  logic        div_busyE,
    input  logic        flush_excM,
    output logic        stallF,
    output logic        stallD,
    output logic        stallE,
    output logic        stallM,
    output logic        stallW,
    output logic        flushD,
    output logic        flushE,
    output logic        flushM,
    output logic        flushW
`ifdef PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] perf_mem_stall_cyc,
    output logic [CNT_W-1:0] perf_div_stall_cyc
`endif
);

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("pipe_stall_ctrl: CNT_W must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic        served;
    logic [31:0] rdata_hold;
    logic        req_raw;
    logic        mem_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            served     <= 1'b0;
            rdata_hold <= 32'd0;
        end else begin
            state <= state_nxt;
            // completion marks the op served; any advance or flush of M re-arms it
            if (state == DATA && mem.data_data_ok) begin
                served     <= 1'b1;
                rdata_hold <= mem.data_rdata;
            end else if (!stallM || flushM) begin
                served <= 1'b0;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        req_raw   = 1'b0;
        mem_stall = 1'b0;
        case (state)
            IDLE: begin
                req_raw   = mem_enM & ~served & ~flush_excM;
                mem_stall = req_raw;
                if (req_raw && mem.data_addr_ok)
                    state_nxt = DATA;
            end
            DATA: begin
                mem_stall = ~mem.data_data_ok;
                if (mem.data_data_ok)
                    state_nxt = IDLE;
                else if (flush_excM)
                    state_nxt = DRAIN;
            end
            DRAIN: begin
                // the orphaned response must be swallowed before a new request goes out
                mem_stall = mem_enM;
                if (mem.data_data_ok)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign mem.data_req = req_raw & ~rst;
    assign mem_rdataM   = (state == DATA && mem.data_data_ok) ? mem.data_rdata : rdata_hold;

    always_comb begin
        stallF = 1'b0;
        stallD = 1'b0;
        stallE = 1'b0;
        stallM = 1'b0;
        stallW = 1'b0;
        flushD = 1'b0;
        flushE = 1'b0;
        flushM = 1'b0;
        flushW = 1'b0;
        if (rst) begin
            stallF = 1'b0;
        end else if (flush_excM) begin
            flushD = 1'b1;
            flushE = 1'b1;
            flushM = 1'b1;
            flushW = 1'b1;
        end else if (mem_stall) begin
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            stallM = 1'b1;
            stallW = 1'b1;
        end else if (div_busyE) begin
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            flushM = 1'b1;
        end else if (lwstallD) begin
            stallF = 1'b1;
            stallD = 1'b1;
            flushE = 1'b1;
        end
    end

`ifdef PERF_CNT_EN
    logic mem_win, div_win;
    assign mem_win = ~rst & ~flush_excM & mem_stall;
    assign div_win = ~rst & ~flush_excM & ~mem_stall & div_busyE;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_mem_stall_cyc <= '0;
            perf_div_stall_cyc <= '0;
        end else begin
            if (mem_win && !(&perf_mem_stall_cyc))
                perf_mem_stall_cyc <= perf_mem_stall_cyc + {{(CNT_W-1){1'b0}}, 1'b1};
            if (div_win && !(&perf_div_stall_cyc))
                perf_div_stall_cyc <= perf_div_stall_cyc + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb/tb_pipe_stall_ctrl.sv - self-checking bench for pipe_stall_ctrl
module tb_pipe_stall_ctrl;

    logic clk;
    logic rst;
    logic mem_enM, lwstallD, div_busyE, flush_excM;
    logic [31:0] mem_rdataM;
    logic stallF, stallD, stallE, stallM, stallW;
    logic flushD, flushE, flushM, flushW;
`ifdef PERF_CNT_EN
    logic [31:0] perf_mem_stall_cyc, perf_div_stall_cyc;
    int unsigned mdl_mem, mdl_div;
    bit perf_ok = 1'b0;
`endif

    pipe_stall_ctrl_if bus();

    pipe_stall_ctrl #(.CNT_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .mem        (bus),
        .mem_enM    (mem_enM),
        .mem_rdataM (mem_rdataM),
        .lwstallD   (lwstallD),
        .div_busyE  (div_busyE),
        .flush_excM (flush_excM),
        .stallF     (stallF),
        .stallD     (stallD),
        .stallE     (stallE),
        .stallM     (stallM),
        .stallW     (stallW),
        .flushD     (flushD),
        .flushE     (flushE),
        .flushM     (flushM),
        .flushW     (flushW)
`ifdef PERF_CNT_EN
        ,
        .perf_mem_stall_cyc (perf_mem_stall_cyc),
        .perf_div_stall_cyc (perf_div_stall_cyc)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // expected bits: {req, stallF,D,E,M,W, flushD,E,M,W}
    localparam logic [9:0] E_NONE = 10'b0_00000_0000;
    localparam logic [9:0] E_MEM  = 10'b0_11111_0000;
    localparam logic [9:0] E_REQ  = 10'b1_11111_0000;
    localparam logic [9:0] E_DIV  = 10'b0_11100_0010;
    localparam logic [9:0] E_LW   = 10'b0_11000_0100;
    localparam logic [9:0] E_EXC  = 10'b0_00000_1111;

    typedef struct {
        string       name;
        logic        rst;
        logic        mem_en;
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] rdata;
        logic        lw;
        logic        div;
        logic        exc;
        logic [9:0]  exp;
        logic        chk;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t sb_q[$];
    vec_t tbl[8];
    int n_chk  = 0;
    int n_fail = 0;

    function automatic vec_t mk(string n, logic r, logic me, logic ao, logic dk, logic [31:0] rd,
                                logic lw, logic dv, logic ex, logic [9:0] e, logic c, logic [31:0] er);
        vec_t v;
        v.name = n; v.rst = r; v.mem_en = me; v.addr_ok = ao; v.data_ok = dk; v.rdata = rd;
        v.lw = lw; v.div = dv; v.exc = ex; v.exp = e; v.chk = c; v.exp_rdata = er;
        return v;
    endfunction

    task automatic check();
        vec_t e;
        logic [9:0] got;
        if (sb_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL scoreboard: queue empty, got 0 entries, required 1");
            return;
        end
        e = sb_q.pop_front();
        got = {bus.data_req, stallF, stallD, stallE, stallM, stallW, flushD, flushE, flushM, flushW};
        n_chk++;
        if (got !== e.exp) begin
            n_fail++;
            $display("FAIL %s ctrl: got req/stall/flush %b, required %b", e.name, got, e.exp);
        end
        if (e.chk) begin
            n_chk++;
            if (mem_rdataM !== e.exp_rdata) begin
                n_fail++;
                $display("FAIL %s rdata: got %h, required %h", e.name, mem_rdataM, e.exp_rdata);
            end
        end
`ifdef PERF_CNT_EN
        if (perf_ok) begin
            n_chk++;
            if (perf_mem_stall_cyc !== mdl_mem || perf_div_stall_cyc !== mdl_div) begin
                n_fail++;
                $display("FAIL %s perf: got mem=%0d div=%0d, required mem=%0d div=%0d", e.name,
                         perf_mem_stall_cyc, perf_div_stall_cyc, mdl_mem, mdl_div);
            end
        end
        if (e.rst) begin
            mdl_mem = 0;
            mdl_div = 0;
            perf_ok = 1'b1;
        end else begin
            if (e.exp[5]) mdl_mem++;
            if (e.exp[6] && e.exp[1]) mdl_div++;
        end
`endif
    endtask

    task automatic run(input vec_t v);
        @(posedge clk);
        #1;
        rst              = v.rst;
        mem_enM          = v.mem_en;
        bus.data_addr_ok = v.addr_ok;
        bus.data_data_ok = v.data_ok;
        bus.data_rdata   = v.rdata;
        lwstallD         = v.lw;
        div_busyE        = v.div;
        flush_excM       = v.exc;
        sb_q.push_back(v);
        @(negedge clk);
        check();
    endtask

    initial begin
        rst = 1'b1; mem_enM = 1'b0; lwstallD = 1'b0; div_busyE = 1'b0; flush_excM = 1'b0;
        bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0; bus.data_rdata = 32'd0;

        tbl[0] = mk("idle",      0, 0, 0, 0, 0, 0, 0, 0, E_NONE, 1, 32'd0);
        tbl[1] = mk("lw",        0, 0, 0, 0, 0, 1, 0, 0, E_LW,   1, 32'd0);
        tbl[2] = mk("div",       0, 0, 0, 0, 0, 0, 1, 0, E_DIV,  1, 32'd0);
        tbl[3] = mk("lw_div",    0, 0, 0, 0, 0, 1, 1, 0, E_DIV,  1, 32'd0);
        tbl[4] = mk("exc",       0, 0, 0, 0, 0, 0, 0, 1, E_EXC,  1, 32'd0);
        tbl[5] = mk("exc_all",   0, 0, 0, 0, 0, 1, 1, 1, E_EXC,  1, 32'd0);
        tbl[6] = mk("exc_memen", 0, 1, 0, 0, 0, 0, 0, 1, E_EXC,  1, 32'd0);
        tbl[7] = mk("exc_lw",    0, 0, 0, 0, 0, 1, 0, 1, E_EXC,  1, 32'd0);

        run(mk("rst0", 1, 1, 0, 0, 0, 1, 1, 0, E_NONE, 1, 32'd0));
        run(mk("rst1", 1, 1, 1, 0, 0, 1, 1, 0, E_NONE, 1, 32'd0));

        for (int i = 0; i < 8; i++) run(tbl[i]);

        // load with three stall cycles, data returned on the fourth
        run(mk("ld_req", 0, 1, 1, 0, 0, 0, 0, 0, E_REQ,  0, 32'd0));
        run(mk("ld_w1",  0, 1, 0, 0, 0, 0, 0, 0, E_MEM,  0, 32'd0));
        run(mk("ld_w2",  0, 1, 0, 0, 0, 0, 0, 0, E_MEM,  0, 32'd0));
        run(mk("ld_dok", 0, 1, 0, 1, 32'hDEADBEEF, 0, 0, 0, E_NONE, 1, 32'hDEADBEEF));

        for (int i = 0; i < 4; i++)
            run(mk("div_hold", 0, 0, 0, 0, 0, 0, 1, 0, E_DIV, 1, 32'hDEADBEEF));
        run(mk("div_done", 0, 0, 0, 0, 0, 0, 0, 0, E_NONE, 1, 32'hDEADBEEF));

        // exception while a load is outstanding, new load waits for the drain
        run(mk("fl_req",  0, 1, 1, 0, 0, 0, 0, 0, E_REQ, 1, 32'hDEADBEEF));
        run(mk("fl_exc",  0, 1, 0, 0, 0, 0, 0, 1, E_EXC, 1, 32'hDEADBEEF));
        run(mk("fl_dr1",  0, 1, 0, 0, 0, 0, 0, 0, E_MEM, 1, 32'hDEADBEEF));
        run(mk("fl_dr2",  0, 1, 0, 0, 0, 0, 0, 0, E_MEM, 1, 32'hDEADBEEF));
        run(mk("fl_drok", 0, 1, 0, 1, 32'h12345678, 0, 0, 0, E_MEM, 1, 32'hDEADBEEF));
        run(mk("fl_req2", 0, 1, 1, 0, 0, 0, 0, 0, E_REQ, 1, 32'hDEADBEEF));
        run(mk("fl_w",    0, 1, 0, 0, 0, 0, 0, 0, E_MEM, 1, 32'hDEADBEEF));
        run(mk("fl_dok",  0, 1, 0, 1, 32'hCAFEF00D, 0, 0, 0, E_NONE, 1, 32'hCAFEF00D));
        run(mk("fl_idle", 0, 0, 0, 0, 0, 0, 0, 0, E_NONE, 1, 32'hCAFEF00D));

        // reset while in DATA
        run(mk("rs_req",   0, 1, 1, 0, 0, 0, 0, 0, E_REQ,  1, 32'hCAFEF00D));
        run(mk("rs_rst",   1, 1, 0, 0, 0, 1, 1, 0, E_NONE, 0, 32'd0));
        run(mk("rs_post",  0, 0, 0, 0, 0, 0, 0, 0, E_NONE, 1, 32'd0));
        run(mk("rs_stray", 0, 0, 0, 1, 32'hFFFFFFFF, 0, 0, 0, E_NONE, 1, 32'd0));
        run(mk("rs_req2",  0, 1, 1, 0, 0, 0, 0, 0, E_REQ,  1, 32'd0));
        run(mk("rs_dok",   0, 1, 0, 1, 32'h55AA55AA, 0, 0, 0, E_NONE, 1, 32'h55AA55AA));
        run(mk("rs_end",   0, 0, 0, 0, 0, 0, 0, 0, E_NONE, 1, 32'h55AA55AA));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
